// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: pipe-register bundles, MEM-stage FSM states,
// load/store funct3 encodings and byte-lane helpers.
package pipeline_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int RF_SIZE    = 5;
  localparam int MEM_BYTES  = DATA_WIDTH / 8;

  localparam int IDX_RS1 = 0;
  localparam int IDX_RS2 = 1;
  localparam int IDX_RD  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;

  localparam logic [2:0] ST_B = 3'b000;
  localparam logic [2:0] ST_H = 3'b001;
  localparam logic [2:0] ST_W = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;

  typedef struct packed {
    logic                      enable;
    logic [DATA_WIDTH-1:0]     PC;
    logic [DATA_WIDTH-1:0]     PC_Next;
    logic [DATA_WIDTH-1:0]     ALU_Result;
    logic [DATA_WIDTH-1:0]     Store_Data;
    logic [2:0][RF_SIZE-1:0]   RegIdx;
    logic                      Reg_WEn;
    logic                      Mem_REn;
    logic                      Mem_WEn;
    logic [2:0]                Detail;
  } EXMEM_Pipe_Out_t;

  typedef struct packed {
    logic                  enable;
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] PC_Next;
    logic [DATA_WIDTH-1:0] WB_Data;
    logic [RF_SIZE-1:0]    RD_Addr;
    logic                  Reg_WEn;
  } MEMWB_Pipe_t;

  // Byte-lane mask for an access size code (low two funct3 bits).
  function automatic logic [MEM_BYTES-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 4'd1;
      2'd1:    size_bytes = 4'd2;
      2'd2:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load extraction: shifts the aligned read word down to the access offset, then
// truncates and sign/zero-extends according to the load funct3.
module mem_load_align
  import pipeline_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            off,
  input  logic [2:0]            detail,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] shifted_s;

  // Lanes beyond the word boundary shift in as zero before extension.
  always_comb begin
    shifted_s = rdata >> {off, 3'b000};
    case (detail)
      LD_B:    load_data = {{56{shifted_s[7]}},  shifted_s[7:0]};
      LD_H:    load_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
      LD_W:    load_data = {{32{shifted_s[31]}}, shifted_s[31:0]};
      LD_BU:   load_data = {56'd0, shifted_s[7:0]};
      LD_HU:   load_data = {48'd0, shifted_s[15:0]};
      LD_WU:   load_data = {32'd0, shifted_s[31:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory loads/stores over req/ack, stalls upstream
// while busy, registers the MEM->WB bundle. Optional MEM_FWD_EN adds forwarding outputs.
module mem_stage
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  EXMEM_Pipe_Out_t       ex_mem_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [MEM_BYTES-1:0]  mem_wstrb_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  misalign_o,
  output MEMWB_Pipe_t           mem_wb_o
`ifdef MEM_FWD_EN
  ,
  output logic                  fwd_valid_o,
  output logic [RF_SIZE-1:0]    fwd_rd_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o
`endif
);

  mem_state_t            state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] pc_r, pc_next_r;
  logic [RF_SIZE-1:0]    rd_r;
  logic                  reg_wen_r;
  logic [2:0]            detail_r;

  logic                  is_mem_s, is_store_s, misalign_s;
  logic [2:0]            off_s;
  logic [MEM_BYTES-1:0]  wstrb_s;
  logic [DATA_WIDTH-1:0] wdata_s, load_data_s;
  logic [RF_SIZE-1:0]    in_rd_s;
  MEMWB_Pipe_t           wb_nxt_s;

  mem_load_align u_load_align (
    .rdata     (mem_rdata_i),
    .off       (mem_addr_o[2:0]),
    .detail    (detail_r),
    .load_data (load_data_s)
  );

  // Request decode, lane generation, next state and stall.
  always_comb begin
    is_mem_s    = ex_mem_i.enable && (ex_mem_i.Mem_REn || ex_mem_i.Mem_WEn);
    is_store_s  = ex_mem_i.Mem_WEn && !ex_mem_i.Mem_REn;
    off_s       = ex_mem_i.ALU_Result[2:0];
    in_rd_s     = ex_mem_i.RegIdx[IDX_RD];
    wstrb_s     = size_mask(ex_mem_i.Detail[1:0]) << off_s;
    wdata_s     = ex_mem_i.Store_Data << {off_s, 3'b000};
    misalign_s  = ({1'b0, off_s} + size_bytes(ex_mem_i.Detail[1:0])) > 4'd8;
    state_nxt_s = state_r;
    stall_o     = 1'b0;
    case (state_r)
      IDLE: begin
        stall_o = is_mem_s;
        if (is_mem_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        stall_o = !mem_ack_i;
        if (mem_ack_i) state_nxt_s = IDLE;
        else           state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next MEM->WB bundle: ALU ops retire straight from IDLE, memory ops on ack.
  always_comb begin
    wb_nxt_s = '0;
    case (state_r)
      IDLE: begin
        if (ex_mem_i.enable && !is_mem_s) begin
          wb_nxt_s.enable  = 1'b1;
          wb_nxt_s.PC      = ex_mem_i.PC;
          wb_nxt_s.PC_Next = ex_mem_i.PC_Next;
          wb_nxt_s.WB_Data = ex_mem_i.ALU_Result;
          wb_nxt_s.RD_Addr = in_rd_s;
          wb_nxt_s.Reg_WEn = ex_mem_i.Reg_WEn && (in_rd_s != 5'd0);
        end else begin
          wb_nxt_s.enable = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          wb_nxt_s.enable  = 1'b1;
          wb_nxt_s.PC      = pc_r;
          wb_nxt_s.PC_Next = pc_next_r;
          wb_nxt_s.WB_Data = mem_we_o ? mem_addr_o : load_data_s;
          wb_nxt_s.RD_Addr = rd_r;
          wb_nxt_s.Reg_WEn = !mem_we_o && reg_wen_r;
        end else begin
          wb_nxt_s.enable = 1'b0;
        end
      end
      default: wb_nxt_s = '0;
    endcase
  end

  // State, memory request registers and the registered WB bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 64'd0;
      mem_wdata_o <= 64'd0;
      mem_wstrb_o <= 8'd0;
      misalign_o  <= 1'b0;
      mem_wb_o    <= '0;
      pc_r        <= 64'd0;
      pc_next_r   <= 64'd0;
      rd_r        <= 5'd0;
      reg_wen_r   <= 1'b0;
      detail_r    <= 3'd0;
    end else begin
      state_r    <= state_nxt_s;
      mem_wb_o   <= wb_nxt_s;
      misalign_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (is_mem_s) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= is_store_s;
            mem_addr_o  <= ex_mem_i.ALU_Result;
            mem_wdata_o <= is_store_s ? wdata_s : 64'd0;
            mem_wstrb_o <= is_store_s ? wstrb_s : 8'd0;
            misalign_o  <= misalign_s;
            pc_r        <= ex_mem_i.PC;
            pc_next_r   <= ex_mem_i.PC_Next;
            rd_r        <= in_rd_s;
            reg_wen_r   <= ex_mem_i.Reg_WEn && (in_rd_s != 5'd0);
            detail_r    <= ex_mem_i.Detail;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wstrb_o <= 8'd0;
          end
        end
        default: mem_req_o <= 1'b0;
      endcase
    end
  end

`ifdef MEM_FWD_EN
  assign fwd_valid_o = mem_wb_o.enable && mem_wb_o.Reg_WEn;
  assign fwd_rd_o    = mem_wb_o.RD_Addr;
  assign fwd_data_o  = mem_wb_o.WB_Data;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against
// a byte-level reference model, with a memory responder of configurable latency.
module tb_mem_stage;
  import pipeline_pkg::*;

  logic clk, rst_n;
  EXMEM_Pipe_Out_t ex_mem;
  logic stall, mem_req, mem_we, mem_ack, misalign;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem_wstrb;
  MEMWB_Pipe_t mem_wb;
`ifdef MEM_FWD_EN
  logic fwd_valid;
  logic [4:0] fwd_rd;
  logic [63:0] fwd_data;
`endif

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_i(ex_mem), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .misalign_o(misalign), .mem_wb_o(mem_wb)
`ifdef MEM_FWD_EN
    , .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data)
`endif
  );

  int n_checks = 0, n_fail = 0;
  int cfg_waits = 0, ack_cnt = 0, resp_cnt = 0;
  bit cfg_rand = 1, resp_en = 1, inject_ack = 0;
  logic [63:0] cfg_rdata = 64'd0;
  logic [7:0] last_strb;
  logic [63:0] last_wdata;
  logic last_we;
  MEMWB_Pipe_t last_wb;
  bit pend_valid = 0, prev_req = 0, mis_seen = 0, last_fwd_valid = 0;
  EXMEM_Pipe_Out_t pend_ins;
  logic [63:0] pend_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sz(logic [2:0] d);
    case (d)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic bit is_mem(EXMEM_Pipe_Out_t i);
    return i.enable && (i.Mem_REn || i.Mem_WEn);
  endfunction

  function automatic bit is_st(EXMEM_Pipe_Out_t i);
    return i.Mem_WEn && !i.Mem_REn;
  endfunction

  function automatic bit m_mis(EXMEM_Pipe_Out_t i);
    return (int'(i.ALU_Result[2:0]) + sz(i.Detail)) > 8;
  endfunction

  function automatic logic [7:0] m_strb(EXMEM_Pipe_Out_t i);
    logic [7:0] s;
    int off, n;
    s = 8'd0; off = int'(i.ALU_Result[2:0]); n = sz(i.Detail);
    if (!is_st(i)) return 8'd0;
    for (int b = 0; b < 8; b++) if (b >= off && b < off + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(EXMEM_Pipe_Out_t i);
    logic [63:0] w;
    int off;
    w = 64'd0; off = int'(i.ALU_Result[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off) w[8*b +: 8] = i.Store_Data[8*(b-off) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] rdata, int off, logic [2:0] d);
    logic [63:0] v;
    int n;
    v = 64'd0; n = sz(d);
    for (int j = 0; j < n; j++)
      if (off + j < 8) v = v | (((rdata >> (8*(off+j))) & 64'hFF) << (8*j));
    if ((d == 3'd0 || d == 3'd1 || d == 3'd2) && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  function automatic MEMWB_Pipe_t m_wb(EXMEM_Pipe_Out_t i, logic [63:0] rdata);
    MEMWB_Pipe_t w;
    logic [4:0] rd;
    rd = i.RegIdx[IDX_RD];
    w = '0;
    w.enable = 1'b1; w.PC = i.PC; w.PC_Next = i.PC_Next; w.RD_Addr = rd;
    if (is_mem(i) && !is_st(i)) begin
      w.WB_Data = m_load(rdata, int'(i.ALU_Result[2:0]), i.Detail);
      w.Reg_WEn = i.Reg_WEn && (rd != 5'd0);
    end else if (is_mem(i)) begin
      w.WB_Data = i.ALU_Result; w.Reg_WEn = 1'b0;
    end else begin
      w.WB_Data = i.ALU_Result; w.Reg_WEn = i.Reg_WEn && (rd != 5'd0);
    end
    return w;
  endfunction

  // Memory responder: acks after cfg_waits request cycles.
  initial begin
    mem_ack = 1'b0; mem_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && mem_req && !mem_ack) begin
        if (resp_cnt >= cfg_waits) begin
          mem_ack = 1'b1;
          mem_rdata = cfg_rand ? {$urandom, $urandom} : cfg_rdata;
          last_strb = mem_wstrb; last_wdata = mem_wdata; last_we = mem_we;
          ack_cnt++; resp_cnt = 0;
        end else resp_cnt++;
      end else begin
        mem_ack = inject_ack; resp_cnt = 0;
      end
    end
  end

  function automatic EXMEM_Pipe_Out_t mk(bit en, bit ren, bit wen, logic [2:0] d,
                                         logic [63:0] addr, logic [63:0] sd,
                                         logic [4:0] rd, bit rwe);
    EXMEM_Pipe_Out_t i;
    i = '0;
    i.enable = en; i.Mem_REn = ren; i.Mem_WEn = wen; i.Detail = d;
    i.ALU_Result = addr; i.Store_Data = sd; i.RegIdx[IDX_RD] = rd; i.Reg_WEn = rwe;
    i.PC = {$urandom, $urandom}; i.PC_Next = i.PC + 64'd4;
    i.RegIdx[IDX_RS1] = 5'($urandom); i.RegIdx[IDX_RS2] = 5'($urandom);
    return i;
  endfunction

  // Present one instruction until consumed, checking every cycle against the model.
  task automatic send(input EXMEM_Pipe_Out_t ins);
    bit done;
    int stalls, exp_st;
    MEMWB_Pipe_t exp_wb;
    logic [7:0] exp_strb;
    bit exp_req, exp_mis;
    done = 0; stalls = 0;
    ex_mem = ins;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (pend_valid) begin
        exp_wb = m_wb(pend_ins, pend_rdata);
        n_checks++;
        if (mem_wb !== exp_wb) begin
          n_fail++; $display("FAIL wb_bundle: got %h expected %h", mem_wb, exp_wb);
        end
        last_wb = mem_wb;
      end else begin
        n_checks++;
        if (mem_wb.enable !== 1'b0) begin
          n_fail++; $display("FAIL wb_bubble: enable got %b expected 0", mem_wb.enable);
        end
      end
`ifdef MEM_FWD_EN
      exp_wb = pend_valid ? m_wb(pend_ins, pend_rdata) : '0;
      n_checks++;
      if (fwd_valid !== (exp_wb.enable && exp_wb.Reg_WEn) ||
          (pend_valid && (fwd_rd !== exp_wb.RD_Addr || fwd_data !== exp_wb.WB_Data))) begin
        n_fail++; $display("FAIL fwd: got v=%b rd=%0d d=%h expected v=%b rd=%0d d=%h",
          fwd_valid, fwd_rd, fwd_data, exp_wb.enable && exp_wb.Reg_WEn, exp_wb.RD_Addr, exp_wb.WB_Data);
      end
      if (pend_valid) last_fwd_valid = fwd_valid;
`endif
      pend_valid = 0;
      exp_req = is_mem(ins) && cyc > 0;
      n_checks++;
      if (mem_req !== exp_req) begin
        n_fail++; $display("FAIL mem_req: got %b expected %b (cycle %0d)", mem_req, exp_req, cyc);
      end
      if (mem_req === 1'b1) begin
        exp_strb = m_strb(ins);
        n_checks++;
        if (mem_we !== is_st(ins) || mem_addr !== ins.ALU_Result || mem_wstrb !== exp_strb ||
            (is_st(ins) && mem_wdata !== m_wdata(ins))) begin
          n_fail++; $display("FAIL mem_bus: got we=%b a=%h s=%h d=%h expected we=%b a=%h s=%h d=%h",
            mem_we, mem_addr, mem_wstrb, mem_wdata, is_st(ins), ins.ALU_Result, exp_strb, m_wdata(ins));
        end
      end
      exp_mis = mem_req && !prev_req && m_mis(ins);
      n_checks++;
      if (misalign !== exp_mis) begin
        n_fail++; $display("FAIL misalign: got %b expected %b", misalign, exp_mis);
      end
      if (misalign === 1'b1) mis_seen = 1;
      prev_req = mem_req;
      if (stall === 1'b0) begin
        if (ins.enable) begin pend_valid = 1; pend_ins = ins; pend_rdata = mem_rdata; end
        done = 1;
      end else stalls++;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++; $display("FAIL send_timeout: stalls got %0d expected <40", stalls);
    end else begin
      exp_st = is_mem(ins) ? cfg_waits + 1 : 0;
      n_checks++;
      if (stalls != exp_st) begin
        n_fail++; $display("FAIL stall_cycles: got %0d expected %0d", stalls, exp_st);
      end
    end
  endtask

  task automatic test_reset();
    ex_mem = mk(1, 0, 0, 3'd0, 64'h55, 64'd0, 5'd3, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_wb !== '0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 8'd0 ||
        mem_addr !== 64'd0 || mem_wdata !== 64'd0 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got wb=%h req=%b we=%b s=%h a=%h d=%h mis=%b expected all 0",
        mem_wb, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, misalign);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ex_mem = '0; prev_req = 0; pend_valid = 0;
  endtask

  task automatic test_alu();
    cfg_waits = 0;
    send(mk(1, 0, 0, 3'd0, 64'h1234, 64'd0, 5'd5, 1));
    send('0);
    n_checks++;
    if (last_wb.enable !== 1'b1 || last_wb.WB_Data !== 64'h1234 || last_wb.RD_Addr !== 5'd5 ||
        last_wb.Reg_WEn !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb: got %h expected data 1234 rd 5 wen 1", last_wb);
    end
  endtask

  task automatic test_load_ext();
    cfg_rand = 0; cfg_waits = 3; cfg_rdata = 64'h0000_0000_8000_0000;
    send(mk(1, 1, 0, LD_B, 64'h1003, 64'd0, 5'd7, 1));
    send('0);
    n_checks++;
    if (last_wb.WB_Data !== 64'hFFFF_FFFF_FFFF_FF80 || last_wb.Reg_WEn !== 1'b1) begin
      n_fail++; $display("FAIL lb_sext: got data %h wen %b expected ffffffffffffff80 1",
        last_wb.WB_Data, last_wb.Reg_WEn);
    end
    send(mk(1, 1, 0, LD_BU, 64'h1003, 64'd0, 5'd7, 1));
    send('0);
    n_checks++;
    if (last_wb.WB_Data !== 64'h80) begin
      n_fail++; $display("FAIL lbu_zext: got %h expected 80", last_wb.WB_Data);
    end
    cfg_rand = 1;
  endtask

  task automatic test_store();
    cfg_waits = 2;
    send(mk(1, 0, 1, ST_H, 64'h2006, 64'hBEEF, 5'd9, 1));
    send('0);
    n_checks++;
    if (last_strb !== 8'hC0 || last_wdata !== 64'hBEEF_0000_0000_0000 || last_we !== 1'b1 ||
        last_wb.Reg_WEn !== 1'b0) begin
      n_fail++; $display("FAIL sh_lanes: got s=%h d=%h we=%b wen=%b expected c0 beef000000000000 1 0",
        last_strb, last_wdata, last_we, last_wb.Reg_WEn);
    end
  endtask

  task automatic test_misalign();
    cfg_rand = 0; cfg_waits = 1; cfg_rdata = 64'h1234_5678_9ABC_DEF0; mis_seen = 0;
    send(mk(1, 1, 0, LD_W, 64'h3006, 64'd0, 5'd4, 1));
    send('0);
    n_checks++;
    if (mis_seen !== 1'b1 || last_strb !== 8'h00 || last_wb.WB_Data !== 64'h1234) begin
      n_fail++; $display("FAIL lw_misalign: got mis=%b s=%h d=%h expected 1 00 1234",
        mis_seen, last_strb, last_wb.WB_Data);
    end
    cfg_rand = 1; cfg_waits = 0;
    send(mk(1, 0, 1, ST_D, 64'h4005, 64'h1122_3344_5566_7788, 5'd0, 0));
    send('0);
    n_checks++;
    if (last_strb !== 8'hE0) begin
      n_fail++; $display("FAIL sd_misalign_strb: got %h expected e0", last_strb);
    end
  endtask

  task automatic test_reset_busy();
    resp_en = 0;
    ex_mem = mk(1, 1, 0, LD_D, 64'h5000, 64'd0, 5'd2, 1);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL busy_req: got %b expected 1", mem_req); end
    @(posedge clk); #1;
    rst_n = 1'b0; ex_mem = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || mem_wb.enable !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got req=%b en=%b stall=%b expected 0 0 0",
        mem_req, mem_wb.enable, stall);
    end
    inject_ack = 1;
    @(negedge clk);
    inject_ack = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (mem_wb.enable !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL late_ack: got en=%b req=%b expected 0 0", mem_wb.enable, mem_req);
      end
    end
    @(posedge clk); #1;
    resp_en = 1; prev_req = 0; pend_valid = 0;
  endtask

  task automatic test_back_to_back();
    int acks0;
    acks0 = ack_cnt;
    cfg_waits = 0;
    send(mk(1, 1, 0, LD_D, 64'h6000, 64'd0, 5'd1, 1));
    send(mk(1, 0, 0, 3'd0, 64'hABCD, 64'd0, 5'd2, 1));
    cfg_waits = 1;
    send(mk(1, 1, 0, LD_D, 64'h6008, 64'd0, 5'd1, 1));
    send(mk(1, 0, 1, ST_W, 64'h6010, 64'hCAFE_F00D, 5'd0, 0));
    send('0);
    n_checks++;
    if (ack_cnt - acks0 != 3) begin
      n_fail++; $display("FAIL b2b_req_count: got %0d expected 3", ack_cnt - acks0);
    end
  endtask

`ifdef MEM_FWD_EN
  task automatic test_fwd();
    cfg_waits = 1;
    send(mk(1, 1, 0, LD_D, 64'h7000, 64'd0, 5'd0, 1));
    send('0);
    n_checks++;
    if (last_fwd_valid !== 1'b0 || last_wb.Reg_WEn !== 1'b0 || last_wb.enable !== 1'b1) begin
      n_fail++; $display("FAIL fwd_rd0: got v=%b wen=%b en=%b expected 0 0 1",
        last_fwd_valid, last_wb.Reg_WEn, last_wb.enable);
    end
  endtask
`endif

  task automatic test_random();
    EXMEM_Pipe_Out_t i;
    int kind;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      cfg_waits = $urandom_range(0, 3);
      case (kind)
        0: i = mk(0, 0, 0, 3'd0, {$urandom, $urandom}, 64'd0, 5'($urandom), 1);
        1: i = mk(1, 0, 0, 3'd0, {$urandom, $urandom}, 64'd0, 5'($urandom), 1'($urandom));
        2: i = mk(1, 1, ($urandom_range(0, 3) == 0), 3'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 5'($urandom), 1'($urandom));
        default: i = mk(1, 0, 1, 3'($urandom_range(0, 3)), {$urandom, $urandom},
                        {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      endcase
      send(i);
    end
    send('0);
  endtask

  initial begin
    rst_n = 1'b0; ex_mem = '0;
    test_reset();
    test_alu();
    test_load_ext();
    test_store();
    test_misalign();
    test_reset_busy();
    test_back_to_back();
`ifdef MEM_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
